// File: rtl/inport_req_ctrl.sv
// Router input-port requester: buffers flits in a small FIFO, XY-routes each head flit,
// holds a one-hot request to the chosen output arbiter and forwards the packet while granted.
module inport_req_ctrl #(
    parameter int FLIT_W  = 16,
    parameter int COORD_W = 1,
    parameter int DEPTH   = 4,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [4:0]        req_out,
    input  logic [4:0]        gnt_in,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic [2:0]        out_port,
    output logic              err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]        DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [COORD_W-1:0] MY_XC   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_YC   = COORD_W'(MY_Y);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [FLIT_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [1:0]         state;
    logic               empty, full, push, pop, grant;
    logic [FLIT_W-1:0]  head;
    logic               head_is_head, head_is_tail;
    logic [COORD_W-1:0] dest_x, dest_y;
    logic [2:0]         route;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign grant    = gnt_in[out_port];

    // Type bit 0 marks a head (01/11), type bit 1 marks a tail (10/11).
    always_comb begin
        head         = mem[rd_ptr];
        head_is_head = head[FLIT_W-2];
        head_is_tail = head[FLIT_W-1];
        dest_x       = head[FLIT_W-3 -: COORD_W];
        dest_y       = head[FLIT_W-3-COORD_W -: COORD_W];
        if (dest_x > MY_XC)      route = 3'd2;
        else if (dest_x < MY_XC) route = 3'd4;
        else if (dest_y > MY_YC) route = 3'd1;
        else if (dest_y < MY_YC) route = 3'd3;
        else                     route = 3'd0;
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = !empty && !head_is_head;
            S_XFER:  pop = grant && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // DRAIN waits for the previous grant to fall so the next packet cannot reuse it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_out   <= '0;
            out_port  <= '0;
            out_flit  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (head_is_head) begin
                            out_port <= route;
                            req_out  <= 5'b00001 << route;
                            state    <= S_XFER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (pop) begin
                        out_flit  <= head;
                        out_valid <= 1'b1;
                        if (head_is_tail) begin
                            req_out <= '0;
                            state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!grant) state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    req_out <= '0;
                end
            endcase
        end
    end
endmodule
